alu_arbiter: RTL

Two-port round-robin arbiter and sequencer that shares the single registered `alu` between requester 0 (execute stage) and requester 1 (branch/compare unit). It accepts operations over valid/ready handshakes, drives the ALU's `enable`/`func`/`a`/`b`, and routes the registered `res` back to the owning requester over a response valid/ready handshake. It sits between the pipeline control and the ALU instance and is the only driver of the ALU inputs.

---
 rtl/alu_arbiter.sv | 63 ++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one registered ALU between two requesters
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int FUNC_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [FUNC_W-1:0] req_func0,
    input  logic [FUNC_W-1:0] req_func1,
    input  logic [WIDTH-1:0]  req_a0,
    input  logic [WIDTH-1:0]  req_b0,
    input  logic [WIDTH-1:0]  req_a1,
    input  logic [WIDTH-1:0]  req_b1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [WIDTH-1:0]  rsp_res,
    output logic              alu_enable,
    output logic [FUNC_W-1:0] alu_func,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    input  logic [WIDTH-1:0]  alu_res,
    output logic              busy
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;
    logic [0:0] state_q, state_d;
    logic       prio_q, prio_d;
    logic       owner_q, owner_d;
    logic       resp, drain, grant, go, issue;
    // grant selection, ALU drive, response routing and next-state decode
    always_comb begin
        resp       = state_q == RESP;
        drain      = resp & rsp_ready[owner_q];
        grant      = &req_valid ? prio_q : req_valid[1];
        go         = (~resp | drain) & (|req_valid);
        issue      = go & reset_n;
        req_ready  = issue ? (grant ? 2'b10 : 2'b01) : 2'b00;
        alu_enable = issue;
        alu_func   = issue ? (grant ? req_func1 : req_func0) : '0;
        alu_a      = issue ? (grant ? req_a1 : req_a0) : '0;
        alu_b      = issue ? (grant ? req_b1 : req_b0) : '0;
        rsp_valid  = resp ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        rsp_res    = resp ? alu_res : '0;
        busy       = resp;
        state_d    = go ? RESP : (drain ? IDLE : state_q);
        owner_d    = go ? grant : owner_q;
        prio_d     = go ? ~grant : prio_q;
    end
    // state, round-robin pointer and result owner registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
        end
    end
endmodule
